// File: rtl/sys_oci_dct_pkg.sv
// rtl/sys_oci_dct_pkg.sv - shared widths, state and frame types for the OCI DCT sequencer
package sys_oci_dct_pkg;

    localparam int ATOM_W = 2;
    localparam int ATOMS  = 15;
    localparam int BUF_W  = ATOM_W * ATOMS;
    localparam int CNT_W  = 4;
    localparam int IDX_W  = $clog2(BUF_W);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } dct_state_t;

    typedef struct packed {
        logic [BUF_W-1:0] data;
        logic [CNT_W-1:0] count;
    } dct_frame_t;

endpackage

// File: rtl/sys_nios2_qsys_0_oci_dct_sequencer_if.sv
// rtl/sys_nios2_qsys_0_oci_dct_sequencer_if.sv - frame handshake between sequencer and trace RAM writer
interface sys_nios2_qsys_0_oci_dct_sequencer_if;
    import sys_oci_dct_pkg::*;

    logic             frm_valid;
    logic             frm_ready;
    logic [BUF_W-1:0] frm_data;
    logic [CNT_W-1:0] frm_count;

    modport master (output frm_valid, output frm_data, output frm_count, input frm_ready);
    modport slave  (input frm_valid, input frm_data, input frm_count, output frm_ready);

endinterface

// File: rtl/sys_oci_dct_frame_reg.sv
// rtl/sys_oci_dct_frame_reg.sv - single-entry valid/ready frame holding register
module sys_oci_dct_frame_reg
    import sys_oci_dct_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load,
    input  dct_frame_t load_frame,
    input  logic       ready,
    output logic       valid,
    output dct_frame_t frame,
    output logic       frees
);

    // A load is only issued when frees is high, so it may overwrite a frame being consumed.
    assign frees = !valid || ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= 1'b0;
            frame <= '0;
        end else if (load) begin
            valid <= 1'b1;
            frame <= load_frame;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/sys_nios2_qsys_0_oci_dct_sequencer.sv
// rtl/sys_nios2_qsys_0_oci_dct_sequencer.sv - DCT atom packer and frame sequencer; DCT_DROP_COUNT_EN enables drop_cnt
module sys_nios2_qsys_0_oci_dct_sequencer
    import sys_oci_dct_pkg::*;
(
    input  logic                                    clk,
    input  logic                                    reset_n,
    input  logic                                    atom_valid,
    input  logic [ATOM_W-1:0]                       atom_data,
    input  logic                                    flush_req,
    input  logic                                    test_ending,
    output logic [BUF_W-1:0]                        dct_buffer,
    output logic [CNT_W-1:0]                        dct_count,
    sys_nios2_qsys_0_oci_dct_sequencer_if.master    frm,
    output logic                                    test_has_ended,
    output logic [15:0]                             drop_cnt
);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(ATOMS);

    dct_state_t       state, state_next;
    logic             accept;
    logic             transfer;
    logic             frees;
    logic             frame_valid;
    logic [CNT_W-1:0] count_next;
    logic [BUF_W-1:0] buf_next;
    logic [IDX_W-1:0] wr_idx;
    dct_frame_t       load_frame;
    dct_frame_t       frame_q;

    assign accept     = (state == RUN) && atom_valid;
    assign count_next = dct_count + CNT_W'(accept);

    // The same-cycle atom is merged before the transfer decision so a flush includes it.
    always_comb begin
        wr_idx   = IDX_W'(dct_count) * IDX_W'(ATOM_W);
        buf_next = dct_buffer;
        if (accept) begin
            buf_next[wr_idx +: ATOM_W] = atom_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            RUN: begin
                if (test_ending) begin
                    state_next = DRAIN;
                end else if (count_next == FULL && !frees) begin
                    state_next = STALL;
                end
            end
            STALL: begin
                if (frees) begin
                    state_next = test_ending ? DRAIN : RUN;
                end
            end
            DRAIN: begin
                if (dct_count == '0 && !frame_valid) begin
                    state_next = DONE;
                end
            end
            DONE: state_next = DONE;
            default: state_next = RUN;
        endcase
    end

    always_comb begin
        transfer       = 1'b0;
        test_has_ended = 1'b0;
        unique case (state)
            RUN:     transfer = frees && (count_next == FULL || (flush_req && count_next != '0));
            STALL:   transfer = frees;
            DRAIN:   transfer = frees && dct_count != '0;
            DONE:    test_has_ended = 1'b1;
            default: transfer = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dct_buffer <= '0;
            dct_count  <= '0;
        end else if (transfer) begin
            dct_buffer <= '0;
            dct_count  <= '0;
        end else if (accept) begin
            dct_buffer <= buf_next;
            dct_count  <= count_next;
        end
    end

    assign load_frame = '{data: buf_next, count: count_next};

    sys_oci_dct_frame_reg u_frame_reg (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (transfer),
        .load_frame (load_frame),
        .ready      (frm.frm_ready),
        .valid      (frame_valid),
        .frame      (frame_q),
        .frees      (frees)
    );

    assign frm.frm_valid = frame_valid;
    assign frm.frm_data  = frame_q.data;
    assign frm.frm_count = frame_q.count;

`ifdef DCT_DROP_COUNT_EN
    logic drop;
    assign drop = (state == STALL) && atom_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt <= '0;
        end else if (drop && drop_cnt != 16'hFFFF) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end
`else
    assign drop_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_sys_nios2_qsys_0_oci_dct_sequencer.sv
// tb/tb_sys_nios2_qsys_0_oci_dct_sequencer.sv - self-checking bench: vector table, corner sequences, random vs queue model
module tb_sys_nios2_qsys_0_oci_dct_sequencer;
    import sys_oci_dct_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        atom_valid = 1'b0;
    logic [1:0]  atom_data = 2'b00;
    logic        flush_req = 1'b0;
    logic        test_ending = 1'b0;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        test_has_ended;
    logic [15:0] drop_cnt;

    sys_nios2_qsys_0_oci_dct_sequencer_if frm_if ();

    sys_nios2_qsys_0_oci_dct_sequencer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .atom_valid     (atom_valid),
        .atom_data      (atom_data),
        .flush_req      (flush_req),
        .test_ending    (test_ending),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .frm            (frm_if),
        .test_has_ended (test_has_ended),
        .drop_cnt       (drop_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: atoms live in a queue, the held frame is a copy of that queue.
    localparam int M_RUN = 0, M_STALL = 1, M_DRAIN = 2, M_DONE = 3;
    int m_buf[$];
    int m_frame[$];
    bit m_fv;
    int m_mode;
    int m_drops;

    function automatic logic [29:0] pack(input int q[$]);
        logic [29:0] d;
        d = '0;
        foreach (q[i]) d[2*i +: 2] = 2'(q[i]);
        return d;
    endfunction

    function automatic logic [15:0] exp_drop();
`ifdef DCT_DROP_COUNT_EN
        return 16'(m_drops);
`else
        return 16'h0;
`endif
    endfunction

    task automatic model_reset();
        m_buf = {};
        m_frame = {};
        m_fv = 1'b0;
        m_mode = M_RUN;
        m_drops = 0;
    endtask

    task automatic model_step();
        bit frees;
        bit load;
        bit idle;
        frees = !m_fv || frm_if.frm_ready;
        idle = (m_buf.size() == 0) && !m_fv;
        load = 1'b0;
        case (m_mode)
            M_RUN: begin
                if (atom_valid) m_buf.push_back(int'(atom_data));
                load = frees && (m_buf.size() == ATOMS || (flush_req && m_buf.size() > 0));
            end
            M_STALL: begin
                if (atom_valid && m_drops < 65535) m_drops++;
                load = frees;
            end
            M_DRAIN: load = frees && m_buf.size() > 0;
            default: load = 1'b0;
        endcase
        if (load) begin
            m_frame = m_buf;
            m_buf = {};
            m_fv = 1'b1;
        end else if (m_fv && frm_if.frm_ready) begin
            m_fv = 1'b0;
        end
        case (m_mode)
            M_RUN: begin
                if (test_ending) m_mode = M_DRAIN;
                else if (m_buf.size() == ATOMS) m_mode = M_STALL;
            end
            M_STALL: if (frees) m_mode = test_ending ? M_DRAIN : M_RUN;
            M_DRAIN: if (idle) m_mode = M_DONE;
            default: ;
        endcase
    endtask

    task automatic check_model();
        chk("m_dct_count", 32'(dct_count), 32'(m_buf.size()));
        chk("m_dct_buffer", 32'(dct_buffer), 32'(pack(m_buf)));
        chk("m_frm_valid", 32'(frm_if.frm_valid), 32'(m_fv));
        if (m_fv) begin
            chk("m_frm_count", 32'(frm_if.frm_count), 32'(m_frame.size()));
            chk("m_frm_data", 32'(frm_if.frm_data), 32'(pack(m_frame)));
        end
        chk("m_test_has_ended", 32'(test_has_ended), 32'(m_mode == M_DONE));
        chk("m_drop_cnt", 32'(drop_cnt), 32'(exp_drop()));
    endtask

    task automatic drive(input bit av, input bit [1:0] ad, input bit fl, input bit rdy, input bit te);
        atom_valid = av;
        atom_data = ad;
        flush_req = fl;
        frm_if.frm_ready = rdy;
        test_ending = te;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_dct_buffer"}, 32'(dct_buffer), 32'h0);
        chk({tag, "_dct_count"}, 32'(dct_count), 32'h0);
        chk({tag, "_frm_valid"}, 32'(frm_if.frm_valid), 32'h0);
        chk({tag, "_frm_data"}, 32'(frm_if.frm_data), 32'h0);
        chk({tag, "_frm_count"}, 32'(frm_if.frm_count), 32'h0);
        chk({tag, "_test_has_ended"}, 32'(test_has_ended), 32'h0);
        chk({tag, "_drop_cnt"}, 32'(drop_cnt), 32'h0);
    endtask

    // Assert reset between edges, confirm outputs clear at once, release on a falling edge.
    task automatic async_reset(input string tag);
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero(tag);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    typedef struct {
        bit        av;
        bit [1:0]  ad;
        bit        fl;
        bit        rdy;
        bit        te;
        bit [3:0]  e_cnt;
        bit        e_fv;
        bit [3:0]  e_fc;
        bit [29:0] e_fd;
    } vec_t;

    function automatic vec_t v(input bit av, input bit [1:0] ad, input bit fl, input bit rdy,
                               input bit [3:0] e_cnt, input bit e_fv, input bit [3:0] e_fc,
                               input bit [29:0] e_fd);
        vec_t r;
        r.av = av; r.ad = ad; r.fl = fl; r.rdy = rdy; r.te = 1'b0;
        r.e_cnt = e_cnt; r.e_fv = e_fv; r.e_fc = e_fc; r.e_fd = e_fd;
        return r;
    endfunction

    initial begin
        vec_t tbl[$];
        bit   saw7;
        int   ready_pct;

        for (int i = 0; i < 14; i++) tbl.push_back(v(1, 2'b01, 0, 1, 4'(i + 1), 0, 0, 0));
        tbl.push_back(v(1, 2'b01, 0, 1, 0, 1, 15, 30'h15555555));
        tbl.push_back(v(1, 2'b11, 0, 1, 1, 0, 0, 0));
        tbl.push_back(v(1, 2'b10, 0, 1, 2, 0, 0, 0));
        tbl.push_back(v(1, 2'b01, 0, 1, 3, 0, 0, 0));
        tbl.push_back(v(0, 2'b00, 1, 1, 0, 1, 3, 30'h0000001B));
        tbl.push_back(v(1, 2'b11, 0, 1, 1, 0, 0, 0));
        tbl.push_back(v(1, 2'b10, 0, 1, 2, 0, 0, 0));
        tbl.push_back(v(1, 2'b01, 1, 1, 0, 1, 3, 30'h0000001B));
        tbl.push_back(v(0, 2'b00, 0, 1, 0, 0, 0, 0));
        tbl.push_back(v(0, 2'b00, 1, 1, 0, 0, 0, 0));

        frm_if.frm_ready = 1'b0;
        model_reset();
        #1 reset_n = 1'b0;
        #1 check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].av, tbl[i].ad, tbl[i].fl, tbl[i].rdy, tbl[i].te);
            step();
            chk($sformatf("tbl%0d_dct_count", i), 32'(dct_count), 32'(tbl[i].e_cnt));
            chk($sformatf("tbl%0d_frm_valid", i), 32'(frm_if.frm_valid), 32'(tbl[i].e_fv));
            if (tbl[i].e_fv) begin
                chk($sformatf("tbl%0d_frm_count", i), 32'(frm_if.frm_count), 32'(tbl[i].e_fc));
                chk($sformatf("tbl%0d_frm_data", i), 32'(frm_if.frm_data), 32'(tbl[i].e_fd));
            end
        end

        // Backpressure: 35 atoms with the writer stalled.
        for (int i = 0; i < 35; i++) begin
            drive(1, 2'($urandom_range(0, 3)), 0, 0, 0);
            step();
        end
        chk("stall_dct_count", 32'(dct_count), 32'd15);
        chk("stall_frm_valid", 32'(frm_if.frm_valid), 32'd1);
`ifdef DCT_DROP_COUNT_EN
        chk("stall_drop_cnt", 32'(drop_cnt), 32'd5);
`else
        chk("stall_drop_cnt", 32'(drop_cnt), 32'd0);
`endif
        drive(0, 0, 0, 1, 0);
        step();
        chk("unstall_frm_valid", 32'(frm_if.frm_valid), 32'd1);
        chk("unstall_frm_count", 32'(frm_if.frm_count), 32'd15);
        chk("unstall_dct_count", 32'(dct_count), 32'd0);
        drive(1, 2'b10, 0, 1, 0);
        step();
        chk("run_again_dct_count", 32'(dct_count), 32'd1);
        chk("run_again_frm_valid", 32'(frm_if.frm_valid), 32'd0);

        // End-of-test drain with 7 buffered atoms.
        drive(0, 0, 1, 1, 0);
        step();
        drive(0, 0, 0, 1, 0);
        step();
        for (int i = 0; i < 7; i++) begin
            drive(1, 2'($urandom_range(0, 3)), 0, 1, 0);
            step();
        end
        drive(0, 0, 0, 1, 1);
        step();
        saw7 = 1'b0;
        for (int i = 0; i < 10 && !test_has_ended; i++) begin
            step();
            if (frm_if.frm_valid && frm_if.frm_count == 4'd7) saw7 = 1'b1;
        end
        chk("drain_frame7_seen", 32'(saw7), 32'd1);
        chk("drain_test_has_ended", 32'(test_has_ended), 32'd1);
        for (int i = 0; i < 3; i++) begin
            drive(1, 2'b11, 0, 1, 1);
            step();
        end
        chk("done_dct_count", 32'(dct_count), 32'd0);
        chk("done_sticky", 32'(test_has_ended), 32'd1);

        // Async reset with a held frame and 9 buffered atoms.
        async_reset("rst_done");
        for (int i = 0; i < 24; i++) begin
            drive(1, 2'($urandom_range(0, 3)), 0, 0, 0);
            step();
        end
        chk("pre_rst_frm_valid", 32'(frm_if.frm_valid), 32'd1);
        chk("pre_rst_dct_count", 32'(dct_count), 32'd9);
        async_reset("rst_mid");
        drive(1, 2'b01, 0, 1, 0);
        step();
        chk("post_rst_dct_count", 32'(dct_count), 32'd1);

        // Random traffic against the queue model, with occasional async resets.
        ready_pct = 50;
        for (int n = 0; n < 4000; n++) begin
            if (n % 500 == 0) ready_pct = (n / 500) % 3 == 0 ? 10 : ((n / 500) % 3 == 1 ? 50 : 90);
            if ($urandom_range(0, 799) == 0) async_reset("rnd_rst");
            drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom_range(0, 9) == 0,
                  $urandom_range(0, 99) < ready_pct, 0);
            step();
        end
        for (int n = 0; n < 200 && !test_has_ended; n++) begin
            drive($urandom_range(0, 1) != 0, 2'($urandom_range(0, 3)), $urandom_range(0, 9) == 0,
                  $urandom_range(0, 1) != 0, 1);
            step();
        end
        chk("rnd_drain_done", 32'(test_has_ended), 32'd1);

`ifdef DCT_DROP_COUNT_EN
        async_reset("sat_rst");
        for (int i = 0; i < 30; i++) begin
            drive(1, 2'b11, 0, 0, 0);
            step();
        end
        for (int i = 0; i < 65540; i++) begin
            drive(1, 2'b01, 0, 0, 0);
            step();
        end
        chk("sat_drop_cnt", 32'(drop_cnt), 32'h0000FFFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
